ov7670_stream_gen: RTL

Synthesizable OV7670 sensor emulator. It is the transmit side of the camera pixel interface: it drives VSYNC/HREF/D byte streams in OV7670 RGB565 VGA timing, so ov7670_capture and the downstream core/VGA path can run on-board and in simulation without a camera. Its outputs are registered on clk. The capture side uses the same clk as its pclk.

---
 rtl/ov7670_stream_gen.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/ov7670_stream_gen.sv
// ov7670_stream_gen: OV7670 RGB565 VGA-timing byte stream emulator.
// Ports: clk/rst_n, enable, mode, fixed_px in; vsync/href/d, frame_start/done, frame_cnt, busy out.
module ov7670_stream_gen #(
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int H_BLANK = 288,
  parameter int V_SYNC  = 3,
  parameter int V_BACK  = 17,
  parameter int V_FRONT = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [15:0] fixed_px,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  d,
  output logic        frame_start,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        busy
);

  localparam int L    = 2 * WIDTH + H_BLANK;
  localparam int VM_A = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
  localparam int VM_B = (HEIGHT > V_FRONT) ? HEIGHT : V_FRONT;
  localparam int VMAX = ((VM_A > VM_B) ? VM_A : VM_B) - 1;
  localparam int HW   = $clog2(L - 1) + 1;
  localparam int VW   = $clog2(VMAX) + 1;

  localparam logic [HW-1:0] H_LAST = HW'(L - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(2 * WIDTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_VSYNC  = 3'd1;
  localparam logic [2:0] S_VBACK  = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_VFRONT = 3'd4;

  logic [2:0]    state;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [VW-1:0] v_last;
  logic [1:0]    mode_q;
  logic [15:0]   fixed_q;
  logic [15:0]   frame_cnt_q;

  logic        line_end;
  logic        frame_end;
  logic        vsync_c;
  logic        href_c;
  logic        fs_c;
  logic        busy_c;
  logic [7:0]  d_c;
  logic [31:0] p32;
  logic [2:0]  bar;
  logic [15:0] bar_px;
  logic [15:0] px;
  logic [4:0]  row5;
  logic [5:0]  p6;

  assign frame_cnt = frame_cnt_q;

  always_comb begin
    v_last = '0;
    unique case (state)
      S_VSYNC:  v_last = VW'(V_SYNC - 1);
      S_VBACK:  v_last = VW'(V_BACK - 1);
      S_ACTIVE: v_last = VW'(HEIGHT - 1);
      S_VFRONT: v_last = VW'(V_FRONT - 1);
      default:  v_last = '0;
    endcase
  end

  assign line_end  = (h_cnt == H_LAST);
  assign frame_end = (state == S_VFRONT) && line_end
                     && (v_cnt == v_last);

  assign vsync_c = (state == S_VSYNC);
  assign href_c  = (state == S_ACTIVE) && (h_cnt < H_ACT);
  assign fs_c    = vsync_c && (h_cnt == '0) && (v_cnt == '0);
  assign busy_c  = (state != S_IDLE);

  // 32-bit product keeps p*8 exact for WIDTH up to 4096
  assign p32  = 32'(h_cnt >> 1);
  assign bar  = 3'((p32 * 32'd8) / 32'(WIDTH));
  assign row5 = 5'(v_cnt);
  assign p6   = 6'(h_cnt >> 1);

  always_comb begin
    bar_px = 16'h0000;
    unique case (bar)
      3'd0: bar_px = 16'hFFFF;
      3'd1: bar_px = 16'hFFE0;
      3'd2: bar_px = 16'h07FF;
      3'd3: bar_px = 16'h07E0;
      3'd4: bar_px = 16'hF81F;
      3'd5: bar_px = 16'hF800;
      3'd6: bar_px = 16'h001F;
      3'd7: bar_px = 16'h0000;
      default: bar_px = 16'h0000;
    endcase
  end

  always_comb begin
    px = 16'h0000;
    unique case (mode_q)
      2'd1:    px = bar_px;
      2'd2:    px = {row5, p6, row5};
      2'd3:    px = fixed_q;
      default: px = 16'h0000;
    endcase
  end

  always_comb begin
    d_c = 8'h00;
    if (href_c) begin
      if (mode_q == 2'd0) d_c = 8'(h_cnt);
      else if (h_cnt[0])  d_c = px[7:0];
      else                d_c = px[15:8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      h_cnt       <= '0;
      v_cnt       <= '0;
      mode_q      <= 2'd0;
      fixed_q     <= 16'h0000;
      frame_cnt_q <= 16'h0000;
      vsync       <= 1'b0;
      href        <= 1'b0;
      d           <= 8'h00;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      vsync       <= vsync_c;
      href        <= href_c;
      d           <= d_c;
      frame_start <= fs_c;
      frame_done  <= frame_end;
      busy        <= busy_c;
      if (frame_end) frame_cnt_q <= frame_cnt_q + 16'd1;

      if (state == S_IDLE) begin
        h_cnt <= '0;
        v_cnt <= '0;
        if (enable) begin
          state   <= S_VSYNC;
          mode_q  <= mode;
          fixed_q <= fixed_px;
        end
      end else if (!line_end) begin
        h_cnt <= h_cnt + HW'(1);
      end else begin
        h_cnt <= '0;
        if (v_cnt != v_last) begin
          v_cnt <= v_cnt + VW'(1);
        end else begin
          v_cnt <= '0;
          unique case (state)
            S_VSYNC:  state <= S_VBACK;
            S_VBACK:  state <= S_ACTIVE;
            S_ACTIVE: state <= S_VFRONT;
            default: begin
              if (enable) begin
                state   <= S_VSYNC;
                mode_q  <= mode;
                fixed_q <= fixed_px;
              end else begin
                state <= S_IDLE;
              end
            end
          endcase
        end
      end
    end
  end

endmodule
